// File: rtl/gb80_mem_bridge_pkg.sv
// Shared types and constants for the GB80 memory bridge: FSM encoding,
// internal address map and the data returned by a timed-out read.
package gb80_mem_bridge_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RD_WAIT,
    ST_RD_RESP,
    ST_WR_DRAIN
  } state_t;

  localparam logic [15:0] HRAM_BASE_ADDR = 16'hFF80;
  localparam logic [15:0] IE_ADDR        = 16'hFFFF;
  localparam logic [7:0]  RD_ERR_DEFAULT = 8'hFF;
  localparam int          HRAM_DEPTH     = 127;

endpackage

// File: rtl/gb80_hram.sv
// 127-byte high RAM: combinational read, write on the clock edge.
module gb80_hram
  import gb80_mem_bridge_pkg::*;
(
  input  logic       i_clock,
  input  logic       i_we,
  input  logic [6:0] i_addr,
  input  logic [7:0] i_wdata,
  output logic [7:0] o_rdata
);

  logic [7:0] r_mem [0:HRAM_DEPTH-1];

  always_ff @(posedge i_clock) begin
    if (i_we) r_mem[i_addr] <= i_wdata;
  end

  assign o_rdata = r_mem[i_addr];

endmodule

// File: rtl/gb80_mem_bridge.sv
// GB80 CPU bus bridge: HRAM/IE served internally with zero wait, everything
// else forwarded to a req/ack port with posted writes and an ack timeout.
module gb80_mem_bridge
  import gb80_mem_bridge_pkg::*;
#(
  parameter int unsigned TIMEOUT      = 255,
  parameter logic [15:0] HRAM_BASE    = HRAM_BASE_ADDR,
  parameter logic [7:0]  RD_ERR_VALUE = RD_ERR_DEFAULT
) (
  input  logic        i_clock,
  input  logic        i_reset,
  input  logic [15:0] i_addr_ext,
  inout  wire  [7:0]  io_data_ext,
  input  logic        i_mem_re,
  input  logic        i_mem_we,
  output logic        o_cpu_wait,
  output logic        o_ext_req,
  output logic        o_ext_we,
  output logic [15:0] o_ext_addr,
  output logic [7:0]  o_ext_wdata,
  input  logic [7:0]  i_ext_rdata,
  input  logic        i_ext_ack,
  output logic [7:0]  o_ie_reg,
  output logic        o_bus_err
);

  localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT - 1);

  state_t      r_state, w_state_next;
  logic        r_ext_req, r_ext_we, r_bus_err, r_wbuf_valid;
  logic [15:0] r_ext_addr;
  logic [7:0]  r_ext_wdata, r_ie, r_cnt, r_rd_buf;

  logic        w_hram_hit, w_ie_hit, w_ext_hit;
  logic        w_rd, w_wr, w_ack, w_timeout;
  logic        w_wait, w_start, w_drive;
  logic [7:0]  w_hram_rdata, w_rdata;

  assign w_ie_hit   = (i_addr_ext == IE_ADDR);
  assign w_hram_hit = (i_addr_ext >= HRAM_BASE) && !w_ie_hit;
  assign w_ext_hit  = !w_hram_hit && !w_ie_hit;

  // A simultaneous read and write strobe is resolved as a read.
  assign w_rd = i_mem_re;
  assign w_wr = i_mem_we && !i_mem_re;

  assign w_ack     = i_ext_ack && r_ext_req;
  assign w_timeout = r_ext_req && !i_ext_ack && (r_cnt == TIMEOUT_LAST);

  gb80_hram u_hram (
    .i_clock (i_clock),
    .i_we    (w_hram_hit && w_wr),
    .i_addr  (i_addr_ext[6:0]),
    .i_wdata (io_data_ext),
    .o_rdata (w_hram_rdata)
  );

  always_comb begin
    w_state_next = r_state;
    w_wait       = 1'b0;
    w_start      = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_ext_hit && w_rd) begin
          w_wait       = 1'b1;
          w_start      = 1'b1;
          w_state_next = ST_RD_WAIT;
        end else if (w_ext_hit && w_wr) begin
          w_start      = 1'b1;
          w_state_next = ST_WR_DRAIN;
        end
      end
      ST_RD_WAIT: begin
        w_wait = 1'b1;
        if (w_ack || w_timeout) w_state_next = ST_RD_RESP;
      end
      ST_RD_RESP: w_state_next = ST_IDLE;
      ST_WR_DRAIN: begin
        // Stall any further external access so program order is kept.
        w_wait = r_wbuf_valid && w_ext_hit && (i_mem_re || i_mem_we);
        if (w_ack || w_timeout) w_state_next = ST_IDLE;
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      r_state      <= ST_IDLE;
      r_ext_req    <= 1'b0;
      r_ext_we     <= 1'b0;
      r_ext_addr   <= '0;
      r_ext_wdata  <= '0;
      r_ie         <= '0;
      r_bus_err    <= 1'b0;
      r_cnt        <= '0;
      r_wbuf_valid <= 1'b0;
      r_rd_buf     <= '0;
    end else begin
      r_state <= w_state_next;
      if (w_ie_hit && w_wr) r_ie <= io_data_ext;
      case (r_state)
        ST_IDLE: begin
          if (w_start) begin
            r_ext_req  <= 1'b1;
            r_ext_we   <= w_wr;
            r_ext_addr <= i_addr_ext;
            r_cnt      <= '0;
            if (w_wr) begin
              r_ext_wdata  <= io_data_ext;
              r_wbuf_valid <= 1'b1;
            end
          end
        end
        ST_RD_WAIT, ST_WR_DRAIN: begin
          if (w_ack) begin
            r_ext_req    <= 1'b0;
            r_wbuf_valid <= 1'b0;
            if (r_state == ST_RD_WAIT) r_rd_buf <= i_ext_rdata;
          end else begin
            r_cnt <= r_cnt + 8'd1;
            if (w_timeout) begin
              r_ext_req    <= 1'b0;
              r_wbuf_valid <= 1'b0;
              r_bus_err    <= 1'b1;
              if (r_state == ST_RD_WAIT) r_rd_buf <= RD_ERR_VALUE;
            end
          end
        end
        default: ;
      endcase
    end
  end

  // The response cycle of an external read owns the bus over an internal hit.
  assign w_rdata = (r_state == ST_RD_RESP) ? r_rd_buf :
                   (w_ie_hit ? r_ie : w_hram_rdata);
  assign w_drive = !i_reset &&
                   ((r_state == ST_RD_RESP) || ((w_hram_hit || w_ie_hit) && w_rd));
  assign io_data_ext = w_drive ? w_rdata : 8'hzz;

  assign o_cpu_wait  = w_wait && !i_reset;
  assign o_ext_req   = r_ext_req;
  assign o_ext_we    = r_ext_we;
  assign o_ext_addr  = r_ext_addr;
  assign o_ext_wdata = r_ext_wdata;
  assign o_ie_reg    = r_ie;
  assign o_bus_err   = r_bus_err;

endmodule

// File: tb/tb_gb80_mem_bridge.sv
// Randomized bench for gb80_mem_bridge: CPU driver, delayed-ack slave and a
// transaction-level model predicting wait counts, read data and bus_err.
module tb_gb80_mem_bridge;

  localparam int TMO = 4;

  typedef struct packed {
    logic [15:0] a;
    logic        we;
    logic [7:0]  wd;
  } txn_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] addr = '0;
  logic        re = 1'b0, we = 1'b0;
  logic        tb_drv = 1'b0;
  logic [7:0]  tb_data = '0;
  wire  [7:0]  data_bus;
  logic        cpu_wait, ext_req, ext_we, bus_err;
  logic [15:0] ext_addr;
  logic [7:0]  ext_wdata, ie_reg;
  logic [7:0]  ext_rdata;
  logic        ext_ack;
  logic [7:0]  z8 = 8'hzz;

  int n_checks = 0, n_errors = 0, cyc = 0, free_cyc = 0, ntx = 0;
  bit spur_en = 1'b0;
  logic       m_err = 1'b0;
  logic [7:0] m_ie = '0;
  logic [7:0] m_hram [0:126];
  logic [7:0] smem [0:65535];
  logic [7:0] mmem [0:65535];
  txn_t eq[$];
  int   dq[$];

  assign data_bus = tb_drv ? tb_data : 8'hzz;

  gb80_mem_bridge #(.TIMEOUT(TMO)) dut (
    .i_clock(clk), .i_reset(rst), .i_addr_ext(addr), .io_data_ext(data_bus),
    .i_mem_re(re), .i_mem_we(we), .o_cpu_wait(cpu_wait), .o_ext_req(ext_req),
    .o_ext_we(ext_we), .o_ext_addr(ext_addr), .o_ext_wdata(ext_wdata),
    .i_ext_rdata(ext_rdata), .i_ext_ack(ext_ack), .o_ie_reg(ie_reg), .o_bus_err(bus_err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_val(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // One CPU access; the model predicts stall length and data from the rules.
  task automatic access(input bit re_i, input bit we_i, input logic [15:0] a,
                        input logic [7:0] wd, input int d);
    bit rd, wr, ext;
    int s, start, waits, exp_waits, k;
    logic [7:0] exp_data;
    txn_t t;
    rd = re_i; wr = we_i && !re_i; ext = (a < 16'hFF80);
    exp_data = 8'h00; exp_waits = 0;
    @(posedge clk); #1;
    s = cyc;
    addr = a; re = re_i; we = we_i; tb_data = wd; tb_drv = wr;
    if (ext) begin
      start = (free_cyc > s) ? free_cyc : s;
      t.a = a; t.we = wr; t.wd = wd;
      eq.push_back(t); dq.push_back(d);
      if (rd) begin
        if (d < TMO) begin exp_data = mmem[a]; exp_waits = start - s + 2 + d; end
        else begin exp_data = 8'hFF; exp_waits = start - s + 1 + TMO; m_err = 1'b1; end
        free_cyc = s + exp_waits + 1;
      end else begin
        exp_waits = start - s;
        k = (d < TMO) ? d + 1 : TMO;
        free_cyc = start + k + 1;
        if (d < TMO) mmem[a] = wd; else m_err = 1'b1;
      end
    end else if (rd) begin
      exp_data = (a == 16'hFFFF) ? m_ie : m_hram[a[6:0]];
    end else if (a == 16'hFFFF) m_ie = wd;
    else m_hram[a[6:0]] = wd;
    waits = 0;
    @(negedge clk);
    while (cpu_wait === 1'b1 && waits < 60) begin
      waits++;
      @(negedge clk);
    end
    if (waits >= 60) check_val("wait_bound", {15'd0, cpu_wait}, 16'd0);
    check_val("waits", 16'(waits), 16'(exp_waits));
    if (rd) begin
      check_val("rd_data", {8'd0, data_bus}, {8'd0, exp_data});
      if (ext) check_val("bus_err", {15'd0, bus_err}, {15'd0, m_err});
    end
    ntx++;
    $display("txn %0d: %s addr=%h wdata=%h delay=%0d waits=%0d bus=%h",
             ntx, rd ? "rd" : "wr", a, wd, d, waits, data_bus);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      re = 1'b0; we = 1'b0; tb_drv = 1'b0;
      @(negedge clk);
      check_val("bus_z", {8'd0, data_bus}, {8'd0, z8});
    end
  endtask

  // External slave: acks the n-th request after the programmed delay.
  initial begin : slave
    int cnt, dly;
    bit act;
    txn_t e;
    ext_ack = 1'b0; ext_rdata = '0; act = 1'b0; cnt = 0; dly = 0; e = '0;
    forever begin
      @(posedge clk); #1;
      ext_ack = 1'b0;
      ext_rdata = 8'($urandom);
      if (rst) act = 1'b0;
      else if (ext_req) begin
        if (!act) begin
          act = 1'b1; cnt = 0;
          if (dq.size() == 0 || eq.size() == 0) begin
            check_val("slave_unexpected_req", {15'd0, ext_req}, 16'd0);
            dly = 1000;
          end else begin
            dly = dq.pop_front(); e = eq.pop_front();
          end
        end else cnt++;
        check_val("ext_we", {15'd0, ext_we}, {15'd0, e.we});
        check_val("ext_addr", ext_addr, e.a);
        if (e.we) check_val("ext_wdata", {8'd0, ext_wdata}, {8'd0, e.wd});
        if (cnt == dly) begin
          ext_ack = 1'b1;
          ext_rdata = smem[ext_addr];
          if (ext_we) smem[ext_addr] = ext_wdata;
        end
      end else begin
        act = 1'b0;
        if (spur_en && $urandom_range(0, 2) == 0) ext_ack = 1'b1;
      end
    end
  end

  initial begin : main
    int kind, d;
    logic [15:0] ea, ha;
    logic [7:0] v;
    for (int i = 0; i < 65536; i++) begin
      v = 8'($urandom); smem[i] = v; mmem[i] = v;
    end
    #12;
    check_val("rst_cpu_wait", {15'd0, cpu_wait}, 16'd0);
    check_val("rst_ext_req", {15'd0, ext_req}, 16'd0);
    check_val("rst_ext_we", {15'd0, ext_we}, 16'd0);
    check_val("rst_ext_addr", ext_addr, 16'd0);
    check_val("rst_ext_wdata", {8'd0, ext_wdata}, 16'd0);
    check_val("rst_ie_reg", {8'd0, ie_reg}, 16'd0);
    check_val("rst_bus_err", {15'd0, bus_err}, 16'd0);
    check_val("rst_bus_z", {8'd0, data_bus}, {8'd0, z8});
    @(posedge clk); #1 rst = 1'b0;
    free_cyc = cyc;

    for (int i = 0; i < 127; i++) access(1'b0, 1'b1, 16'hFF80 + 16'(i), 8'($urandom), 0);

    access(1'b0, 1'b1, 16'hFF90, 8'hA5, 0);
    access(1'b1, 1'b0, 16'hFF90, 8'h00, 0);
    access(1'b0, 1'b1, 16'hFFFF, 8'h1F, 0);
    idle(1);
    check_val("ie_reg", {8'd0, ie_reg}, 16'h001F);

    smem[16'h1234] = 8'h3C; mmem[16'h1234] = 8'h3C;
    access(1'b1, 1'b0, 16'h1234, 8'h00, 1);
    idle(1);

    access(1'b0, 1'b1, 16'hC000, 8'h77, 3);
    access(1'b1, 1'b0, 16'hC000, 8'h00, 0);
    idle(1);

    access(1'b0, 1'b1, 16'hC000, 8'h55, 3);
    access(1'b1, 1'b0, 16'hFF80, 8'h00, 0);
    check_val("drain_ext_req", {15'd0, ext_req}, 16'd1);
    idle(5);

    access(1'b1, 1'b0, 16'h8000, 8'h00, 99);
    check_val("tmo_ext_req", {15'd0, ext_req}, 16'd0);
    idle(3);
    check_val("tmo_bus_err_sticky", {15'd0, bus_err}, 16'd1);

    access(1'b1, 1'b1, 16'hFF85, 8'hEE, 0);
    access(1'b1, 1'b0, 16'hFF85, 8'h00, 0);

    // Reset while a read is outstanding.
    @(posedge clk); #1;
    addr = 16'h4000; re = 1'b1; we = 1'b0; tb_drv = 1'b0;
    eq.push_back('{a: 16'h4000, we: 1'b0, wd: 8'h00}); dq.push_back(99);
    repeat (2) @(posedge clk);
    #3 rst = 1'b1;
    #1;
    check_val("rstmid_ext_req", {15'd0, ext_req}, 16'd0);
    check_val("rstmid_cpu_wait", {15'd0, cpu_wait}, 16'd0);
    check_val("rstmid_bus_z", {8'd0, data_bus}, {8'd0, z8});
    re = 1'b0;
    @(posedge clk); #1 rst = 1'b0;
    free_cyc = cyc; m_err = 1'b0; m_ie = '0;
    check_val("rstmid_bus_err", {15'd0, bus_err}, 16'd0);
    check_val("rstmid_ie_reg", {8'd0, ie_reg}, 16'd0);
    access(1'b1, 1'b0, 16'h1234, 8'h00, 0);

    spur_en = 1'b1;
    for (int n = 0; n < 400; n++) begin
      kind = $urandom_range(0, 9);
      d  = ($urandom_range(0, 9) == 0) ? $urandom_range(TMO, TMO + 2) : $urandom_range(0, TMO - 1);
      ea = ($urandom_range(0, 1) == 1) ? (16'hC000 | 16'($urandom_range(0, 7)))
                                        : 16'($urandom_range(0, 16'hFF7F));
      ha = 16'hFF80 | 16'($urandom_range(0, 126));
      v  = 8'($urandom);
      case (kind)
        0, 1, 2: access(1'b1, 1'b0, ea, v, d);
        3, 4:    access(1'b0, 1'b1, ea, v, d);
        5:       access(1'b1, 1'b0, ha, v, d);
        6:       access(1'b0, 1'b1, ha, v, d);
        7: begin
          if ($urandom_range(0, 1) == 1) access(1'b1, 1'b0, 16'hFFFF, v, d);
          else access(1'b0, 1'b1, 16'hFFFF, v, d);
        end
        8: access(1'b1, 1'b1, ($urandom_range(0, 1) == 1) ? ea : ha, v, d);
        default: idle($urandom_range(1, 3));
      endcase
    end
    spur_en = 1'b0;
    idle(TMO + 3);
    check_val("final_bus_err", {15'd0, bus_err}, {15'd0, m_err});
    check_val("final_ie_reg", {8'd0, ie_reg}, {8'd0, m_ie});
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/gb80_mem_bridge.md
Name: gb80_mem_bridge

Overview:
- Sits directly downstream of the GB80 CPU top and consumes its external bus: addr_ext, data_ext, mem_re and mem_we.
- Serves HRAM (0xFF80–0xFFFE) and the IE register (0xFFFF) internally, with zero wait.
- Forwards every other address to a req/ack external memory port. Writes are posted through a one-entry write buffer.
- Drives cpu_wait so that a future CPU stall input can hold the core while an external access is pending.

Parameters:
- TIMEOUT, 255, number of cycles to wait for ext_ack before aborting (valid range 1..255).
- HRAM_BASE, 16'hFF80, first HRAM address.
- RD_ERR_VALUE, 8'hFF, data returned on a read that times out.

Ports:
- clock  input  1  system clock.
- reset  input  1  asynchronous, active-high reset.
- addr_ext  input  16  CPU address bus.
- data_ext  inout  8  CPU data bus. The bridge drives it only during a read response; otherwise it is Z.
- mem_re  input  1  CPU read strobe.
- mem_we  input  1  CPU write strobe.
- cpu_wait  output  1  the CPU access this cycle cannot complete.
- ext_req  output  1  external request valid.
- ext_we  output  1  external request is a write.
- ext_addr  output  16  external address.
- ext_wdata  output  8  external write data.
- ext_rdata  input  8  external read data, valid while ext_ack=1.
- ext_ack  input  1  external transfer complete (one-cycle pulse).
- ie_reg  output  8  IE register contents.
- bus_err  output  1  sticky flag: an external timeout has occurred.

Behaviour:
- Clock and reset: one clock. Reset is asynchronous and active-high.
- Reset values: the state machine goes to IDLE. The following all reset to 0: cpu_wait, ext_req, ext_we, ext_addr, ext_wdata, ie_reg, bus_err, the timeout counter and the write-buffer-valid flag. data_ext is Z. HRAM contents are not reset.
- Address decode:
  - hram_hit = addr_ext >= HRAM_BASE and addr_ext != 16'hFFFF.
  - ie_hit = addr_ext == 16'hFFFF.
  - ext_hit = neither of the above.
- Strobe conflict: if mem_re and mem_we are asserted together, the write is ignored and the access is treated as a read.
- Internal read (hram_hit or ie_hit, mem_re=1):
  - data_ext is driven combinationally the same cycle.
  - cpu_wait=0.
  - Served in any state, including while a posted write drains.
- Internal write (hram_hit or ie_hit, mem_we=1): data_ext is captured on the same posedge, with no wait.
- HRAM storage: 127 x 8 array, indexed by addr_ext[6:0]. Asynchronous read, synchronous write.
- FSM states: IDLE, RD_WAIT, RD_RESP, WR_DRAIN.
- IDLE:
  - ext_hit and mem_re: cpu_wait=1 combinationally. Latch the address, ext_req=1, ext_we=0, go to RD_WAIT.
  - ext_hit and mem_we: cpu_wait=0 (the write is posted). Latch the address and data into ext_addr/ext_wdata, ext_req=1, ext_we=1, go to WR_DRAIN.
- RD_WAIT:
  - cpu_wait=1.
  - On ext_ack: capture ext_rdata into rd_buf, drop ext_req, go to RD_RESP.
- RD_RESP:
  - data_ext = rd_buf, cpu_wait=0, for exactly one cycle.
  - Then go to IDLE.
  - Minimum external read latency is 3 cycles (request, ack, response).
- WR_DRAIN:
  - Hold ext_req, ext_we, ext_addr and ext_wdata stable until ext_ack, then go to IDLE.
  - Any new ext_hit access (read or write) in this state gets cpu_wait=1 and is not accepted until IDLE. This preserves program order, including read-after-write to the same address.
- Timeout:
  - The counter clears on entry to RD_WAIT or WR_DRAIN and increments each cycle without ack.
  - When the counter reaches TIMEOUT: drop ext_req and set bus_err.
    - Reads go to RD_RESP with rd_buf = RD_ERR_VALUE.
    - Writes are discarded; go to IDLE.
- ext_ack rules:
  - ext_ack arriving in the same cycle the counter reaches TIMEOUT: ack wins.
  - ext_ack while ext_req=0 is ignored.
- ext_addr and ext_wdata hold their last values when idle.
- bus_err is cleared only by reset.
- Reset mid-transaction: the state is abandoned immediately and ext_req drops asynchronously. No completion is reported.

Decomposition:
- Shared package/header: the state encodings, the HRAM and IE address constants, and RD_ERR_VALUE.
- One natural sub-module: gb80_hram, the 127-byte asynchronous-read, synchronous-write array.
- Everything else (decode, FSM, timeout counter, bus drivers) lives in gb80_mem_bridge.

Test Plan:
- HRAM round trip: write 8'hA5 to 0xFF90 → read of 0xFF90 returns 8'hA5 in the same cycle with cpu_wait=0. Write 8'h1F to 0xFFFF → ie_reg=8'h1F.
- External read: read 0x1234; slave acks 2 cycles after ext_req with 8'h3C → cpu_wait high for 3 cycles, then data_ext=8'h3C for exactly one cycle, then data_ext is Z.
- Posted write then read: write 8'h77 to 0xC000, then read 0xC000 the next cycle while the slave delays ack by 4 cycles → the write has cpu_wait=0; the read waits until after the write ack and returns the slave's 8'h77.
- HRAM during drain: a write to 0xC000 is pending; read 0xFF80 → served immediately, and ext_req stays held for the write.
- Timeout: TIMEOUT=4, slave never acks a read of 0x8000 → after 4 cycles ext_req drops, data_ext=8'hFF, bus_err=1 and stays set.
- Reset mid RD_WAIT: assert reset → ext_req=0, cpu_wait=0 and data_ext=Z immediately. After release, an external read works normally.
